nvdla_csb_initiator: RTL and testbench
======================================

# nvdla_csb_initiator

CSB request initiator: the master-side end of the csb2xx / xx2csb register protocol. It accepts one register command at a time from a local sequencer or debug port, packs it into the 63-bit csb2xx request, drives the valid/ready handshake toward a unit responder, and waits for the 34-bit xx2csb response. Non-posted writes and reads are guarded by a timeout. It sits between a local command source and any NVDLA unit's CSB slave port, including the GEC responder stub.

## Interface
- TIMEOUT, default 1024: wait-state cycles without a response before forced completion; legal range 2..65535.
- nvdla_core_clk  in  1  sole clock.
- nvdla_core_rstn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both are high.
- cmd_addr  in  22  word address.
- cmd_wdat  in  32  write data.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_nposted  in  1  write expects a response.
- cmd_wrbe  in  4  byte enables.
- cmd_srcpriv  in  1  privileged source.
- cmd_level  in  2  security level.
- csb_req_pvld  out  1  request valid.
- csb_req_prdy  in  1  request ready.
- csb_req_pd  out  63  packed request: [21:0] addr, [53:22] wdat, [54] write, [55] nposted, [56] srcpriv, [60:57] wrbe, [62:61] level.
- csb_resp_valid  in  1  response valid, single-cycle, no backpressure.
- csb_resp_pd  in  34  [31:0] rdat, [32] error, [33] type (0 = read, 1 = write).
- cpl_valid  out  1  one-cycle completion pulse.
- cpl_rdat  out  32  read data (0 for writes and timeouts).
- cpl_error  out  1  responder error, type mismatch, or timeout.
- cpl_timeout  out  1  completion caused by timeout.
- stray_resp  out  1  sticky: response seen outside WAIT; cleared only by reset.

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: cmd_ready = 1. On cmd_valid, register all cmd fields into csb_req_pd and go to REQ.
- REQ: csb_req_pvld = 1; pd is held stable until csb_req_prdy.
  - On handshake, a posted write (write & ~nposted) returns to IDLE and pulses cpl next cycle with rdat 0, error 0.
  - Otherwise go to WAIT with the timeout counter cleared.
- WAIT: counter increments each cycle without csb_resp_valid.
  - On csb_resp_valid: cpl_rdat = resp rdat if the request was a read, else 0.
  - cpl_error = resp error | (resp type != registered write bit).
  - Return to IDLE.
- Timeout: when the counter equals TIMEOUT-1 and no response arrives that cycle, complete with cpl_error = 1, cpl_timeout = 1, rdat = 0, and return to IDLE.
  - If a response and the timeout occur in the same cycle, the response wins.
- csb_resp_valid in IDLE or REQ is dropped and sets stray_resp. A late response after a timeout is therefore recorded, never delivered.
- Counter width is clog2(TIMEOUT). It saturates and never wraps.

## Timing
- Reset values:
  - state IDLE, cmd_ready 1.
  - csb_req_pvld 0, csb_req_pd 0.
  - cpl_valid 0, cpl_rdat 0, cpl_error 0, cpl_timeout 0.
  - stray_resp 0, counter 0.
- Command accepted in cycle T: csb_req_pvld is high from T+1.
- Handshake at cycle H: cmd_ready returns high at H+1 for a posted write, with cpl_valid at H+1.
- Response in cycle R during WAIT: cpl_valid and the cpl fields are registered at R+1, and cmd_ready is high at R+1.
- Against a one-cycle registered responder with prdy tied high, a read completes 3 cycles after command acceptance.
- cpl fields hold their value between pulses.
- Reset asserted mid-transaction: immediate return to reset values. No completion is emitted for the aborted command.

## Structure
- The shared package nvdla_csb_pkg holds:
  - request field offsets/widths and response field offsets;
  - response type constants RESP_RD = 1'b0, RESP_WR = 1'b1;
  - the FSM state enum.
- Single module, no sub-module; pack/unpack is plain field assignment.

## Test plan
- Read addr 0x00_1234, responder returns rdat 0xDEADBEEF, type 0, error 0, prdy high → cpl_valid 3 cycles after acceptance, cpl_rdat 0xDEADBEEF, error 0.
- Posted write (nposted 0), prdy delayed 4 cycles → csb_req_pd stable for all 5 cycles; cpl_valid the cycle after handshake; cmd_ready low until then.
- Non-posted write, response type 0 (mismatch) → cpl_error 1, cpl_rdat 0, cpl_timeout 0.
- Read with TIMEOUT = 8 and no response → cpl_valid 8 WAIT cycles after entering WAIT, with error 1 and timeout 1; a response injected 2 cycles later sets stray_resp.
- Response exactly on the timeout cycle (counter = TIMEOUT-1) → normal completion, cpl_timeout 0.
- Reset pulsed during WAIT → all outputs return to reset values; the next command completes normally.

Source files
------------

// File: rtl/nvdla_csb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nvdla_csb_pkg
//  Description : Shared definitions for the CSB request initiator.
//                - csb2xx request field offsets/widths (63-bit packed request)
//                - xx2csb response field offsets (34-bit packed response)
//                - response type encodings
//                - initiator FSM state enum
//  Revision    : 1.0 - initial release
// ============================================================================
package nvdla_csb_pkg;

   // csb2xx request layout
   localparam int REQ_W          = 63;
   localparam int REQ_ADDR_LSB   = 0;
   localparam int REQ_ADDR_W     = 22;
   localparam int REQ_WDAT_LSB   = 22;
   localparam int REQ_WDAT_W     = 32;
   localparam int REQ_WRITE_BIT  = 54;
   localparam int REQ_NPOST_BIT  = 55;
   localparam int REQ_PRIV_BIT   = 56;
   localparam int REQ_WRBE_LSB   = 57;
   localparam int REQ_WRBE_W     = 4;
   localparam int REQ_LEVEL_LSB  = 61;
   localparam int REQ_LEVEL_W    = 2;

   // xx2csb response layout
   localparam int RESP_W         = 34;
   localparam int RESP_RDAT_LSB  = 0;
   localparam int RESP_RDAT_W    = 32;
   localparam int RESP_ERR_BIT   = 32;
   localparam int RESP_TYPE_BIT  = 33;

   // Response type encodings
   localparam logic RESP_RD = 1'b0;
   localparam logic RESP_WR = 1'b1;

   // Initiator FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } csb_state_e;

endpackage : nvdla_csb_pkg
`default_nettype wire

// File: rtl/nvdla_csb_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : nvdla_csb_initiator
//  Description : Master side of the csb2xx / xx2csb register protocol.
//                Accepts one command at a time, packs it into the 63-bit
//                request, handshakes it to a unit responder and waits for the
//                34-bit response (non-posted writes and reads), with a
//                saturating timeout guard.
//  Ports       :
//    nvdla_core_clk / nvdla_core_rstn  clock, async active-low reset
//    cmd_*                             local command channel (valid/ready)
//    csb_req_pvld/prdy/pd              csb2xx request channel
//    csb_resp_valid/pd                 xx2csb response (no backpressure)
//    cpl_valid/rdat/error/timeout      one-cycle completion report
//    stray_resp                        sticky flag: response seen outside WAIT
//  Revision    : 1.0 - initial release
// ============================================================================
module nvdla_csb_initiator #(
   parameter int TIMEOUT = 1024
) (
   input  logic        nvdla_core_clk,
   input  logic        nvdla_core_rstn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [21:0] cmd_addr,
   input  logic [31:0] cmd_wdat,
   input  logic        cmd_write,
   input  logic        cmd_nposted,
   input  logic [3:0]  cmd_wrbe,
   input  logic        cmd_srcpriv,
   input  logic [1:0]  cmd_level,
   output logic        csb_req_pvld,
   input  logic        csb_req_prdy,
   output logic [62:0] csb_req_pd,
   input  logic        csb_resp_valid,
   input  logic [33:0] csb_resp_pd,
   output logic        cpl_valid,
   output logic [31:0] cpl_rdat,
   output logic        cpl_error,
   output logic        cpl_timeout,
   output logic        stray_resp
);
   import nvdla_csb_pkg::*;

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   csb_state_e        state_q, state_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              req_pvld_q, req_pvld_d;
   logic [REQ_W-1:0]  req_pd_q, req_pd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              cpl_valid_q, cpl_valid_d;
   logic [31:0]       cpl_rdat_q, cpl_rdat_d;
   logic              cpl_error_q, cpl_error_d;
   logic              cpl_timeout_q, cpl_timeout_d;
   logic              stray_q, stray_d;

   logic              w_req_write;
   logic              w_req_posted;
   logic              w_exp_type;
   logic [31:0]       w_resp_rdat;
   logic              w_resp_err;
   logic              w_resp_type;

   assign w_req_write  = req_pd_q[REQ_WRITE_BIT];
   assign w_req_posted = w_req_write & ~req_pd_q[REQ_NPOST_BIT];
   assign w_exp_type   = w_req_write ? RESP_WR : RESP_RD;
   assign w_resp_rdat  = csb_resp_pd[RESP_RDAT_LSB +: RESP_RDAT_W];
   assign w_resp_err   = csb_resp_pd[RESP_ERR_BIT];
   assign w_resp_type  = csb_resp_pd[RESP_TYPE_BIT];

   always_comb begin
      state_d       = state_q;
      req_pd_d      = req_pd_q;
      cnt_d         = cnt_q;
      cpl_valid_d   = 1'b0;
      cpl_rdat_d    = cpl_rdat_q;
      cpl_error_d   = cpl_error_q;
      cpl_timeout_d = cpl_timeout_q;
      // Responses are only meaningful in WAIT; anything else is recorded and dropped.
      stray_d       = stray_q | (csb_resp_valid & (state_q != ST_WAIT));

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               req_pd_d[REQ_ADDR_LSB  +: REQ_ADDR_W]  = cmd_addr;
               req_pd_d[REQ_WDAT_LSB  +: REQ_WDAT_W]  = cmd_wdat;
               req_pd_d[REQ_WRITE_BIT]                = cmd_write;
               req_pd_d[REQ_NPOST_BIT]                = cmd_nposted;
               req_pd_d[REQ_PRIV_BIT]                 = cmd_srcpriv;
               req_pd_d[REQ_WRBE_LSB  +: REQ_WRBE_W]  = cmd_wrbe;
               req_pd_d[REQ_LEVEL_LSB +: REQ_LEVEL_W] = cmd_level;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (csb_req_prdy) begin
               cnt_d = '0;
               if (w_req_posted) begin
                  // Posted write: no response expected, complete right away.
                  state_d       = ST_IDLE;
                  cpl_valid_d   = 1'b1;
                  cpl_rdat_d    = '0;
                  cpl_error_d   = 1'b0;
                  cpl_timeout_d = 1'b0;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // A response on the last counted cycle still wins over the timeout.
            if (csb_resp_valid) begin
               state_d       = ST_IDLE;
               cpl_valid_d   = 1'b1;
               cpl_rdat_d    = w_req_write ? 32'd0 : w_resp_rdat;
               cpl_error_d   = w_resp_err | (w_resp_type != w_exp_type);
               cpl_timeout_d = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               state_d       = ST_IDLE;
               cpl_valid_d   = 1'b1;
               cpl_rdat_d    = '0;
               cpl_error_d   = 1'b1;
               cpl_timeout_d = 1'b1;
            end else begin
               // Only incremented below CNT_LAST, so it can never wrap.
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
      req_pvld_d  = (state_d == ST_REQ);
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state_q       <= ST_IDLE;
         cmd_ready_q   <= 1'b1;
         req_pvld_q    <= 1'b0;
         req_pd_q      <= '0;
         cnt_q         <= '0;
         cpl_valid_q   <= 1'b0;
         cpl_rdat_q    <= '0;
         cpl_error_q   <= 1'b0;
         cpl_timeout_q <= 1'b0;
         stray_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         req_pvld_q    <= req_pvld_d;
         req_pd_q      <= req_pd_d;
         cnt_q         <= cnt_d;
         cpl_valid_q   <= cpl_valid_d;
         cpl_rdat_q    <= cpl_rdat_d;
         cpl_error_q   <= cpl_error_d;
         cpl_timeout_q <= cpl_timeout_d;
         stray_q       <= stray_d;
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign csb_req_pvld = req_pvld_q;
   assign csb_req_pd   = req_pd_q;
   assign cpl_valid    = cpl_valid_q;
   assign cpl_rdat     = cpl_rdat_q;
   assign cpl_error    = cpl_error_q;
   assign cpl_timeout  = cpl_timeout_q;
   assign stray_resp   = stray_q;

endmodule : nvdla_csb_initiator
`default_nettype wire

// File: tb/tb_nvdla_csb_initiator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_nvdla_csb_initiator
//  Description : Self-checking bench for nvdla_csb_initiator (TIMEOUT = 8).
//                Directed scenarios followed by randomized transactions whose
//                expected request packing and completion are derived from the
//                protocol rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nvdla_csb_initiator;

   localparam int TO = 8;

   logic        nvdla_core_clk = 1'b0;
   logic        nvdla_core_rstn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [21:0] cmd_addr = '0;
   logic [31:0] cmd_wdat = '0;
   logic        cmd_write = 1'b0;
   logic        cmd_nposted = 1'b0;
   logic [3:0]  cmd_wrbe = '0;
   logic        cmd_srcpriv = 1'b0;
   logic [1:0]  cmd_level = '0;
   logic        csb_req_pvld;
   logic        csb_req_prdy = 1'b0;
   logic [62:0] csb_req_pd;
   logic        csb_resp_valid = 1'b0;
   logic [33:0] csb_resp_pd = '0;
   logic        cpl_valid;
   logic [31:0] cpl_rdat;
   logic        cpl_error;
   logic        cpl_timeout;
   logic        stray_resp;

   int   checks = 0;
   int   failures = 0;
   logic exp_stray = 1'b0;

   always #5 nvdla_core_clk = ~nvdla_core_clk;

   nvdla_csb_initiator #(.TIMEOUT(TO)) dut (
      .nvdla_core_clk (nvdla_core_clk),
      .nvdla_core_rstn(nvdla_core_rstn),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_addr       (cmd_addr),
      .cmd_wdat       (cmd_wdat),
      .cmd_write      (cmd_write),
      .cmd_nposted    (cmd_nposted),
      .cmd_wrbe       (cmd_wrbe),
      .cmd_srcpriv    (cmd_srcpriv),
      .cmd_level      (cmd_level),
      .csb_req_pvld   (csb_req_pvld),
      .csb_req_prdy   (csb_req_prdy),
      .csb_req_pd     (csb_req_pd),
      .csb_resp_valid (csb_resp_valid),
      .csb_resp_pd    (csb_resp_pd),
      .cpl_valid      (cpl_valid),
      .cpl_rdat       (cpl_rdat),
      .cpl_error      (cpl_error),
      .cpl_timeout    (cpl_timeout),
      .stray_resp     (stray_resp)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge nvdla_core_clk);
      #1;
   endtask

   // Request bit map: [62:61] level, [60:57] wrbe, [56] srcpriv,
   // [55] nposted, [54] write, [53:22] wdat, [21:0] addr.
   function automatic logic [62:0] pack_req(input logic [21:0] a, input logic [31:0] d,
                                            input logic w, input logic np, input logic [3:0] be,
                                            input logic pv, input logic [1:0] lv);
      return {lv, be, pv, np, w, d, a};
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cmd_ready"},   cmd_ready,    1);
      chk({tag, "_pvld"},        csb_req_pvld, 0);
      chk({tag, "_pd"},          csb_req_pd,   0);
      chk({tag, "_cpl_valid"},   cpl_valid,    0);
      chk({tag, "_cpl_rdat"},    cpl_rdat,     0);
      chk({tag, "_cpl_error"},   cpl_error,    0);
      chk({tag, "_cpl_timeout"}, cpl_timeout,  0);
      chk({tag, "_stray"},       stray_resp,   0);
   endtask

   // One full command. resp_dly = index of the WAIT cycle carrying the
   // response; any value outside 0..TO-1 means no response (timeout).
   task automatic run_txn(input logic [21:0] a, input logic [31:0] d, input logic w,
                          input logic np, input logic [3:0] be, input logic pv,
                          input logic [1:0] lv, input int prdy_dly, input int resp_dly,
                          input logic [31:0] rdat, input logic rerr, input logic rtype,
                          output int lat, output int wait_ticks);
      logic [62:0] epd;
      logic [31:0] e_rdat;
      logic        e_err, e_to;
      bit          done;
      epd = pack_req(a, d, w, np, be, pv, lv);
      lat = 0;
      wait_ticks = 0;
      e_rdat = 0; e_err = 0; e_to = 0;
      chk("idle_cmd_ready", cmd_ready, 1);
      cmd_addr = a; cmd_wdat = d; cmd_write = w; cmd_nposted = np;
      cmd_wrbe = be; cmd_srcpriv = pv; cmd_level = lv; cmd_valid = 1'b1;
      tick(); lat++;
      cmd_valid = 1'b0;
      // Scramble inputs: the request must not follow them after acceptance.
      cmd_addr = 22'($urandom); cmd_wdat = $urandom; cmd_write = ~w; cmd_level = ~lv;
      chk("req_pvld", csb_req_pvld, 1);
      chk("req_pd", csb_req_pd, epd);
      chk("req_cmd_ready", cmd_ready, 0);
      for (int i = 0; i < prdy_dly; i++) begin
         tick(); lat++;
         chk("req_pvld_hold", csb_req_pvld, 1);
         chk("req_pd_hold", csb_req_pd, epd);
         chk("req_cmd_ready_hold", cmd_ready, 0);
      end
      csb_req_prdy = 1'b1;
      tick(); lat++;
      csb_req_prdy = 1'b0;
      if (w && !np) begin
         chk("posted_cpl_valid", cpl_valid, 1);
         chk("posted_cmd_ready", cmd_ready, 1);
         e_rdat = 0; e_err = 0; e_to = 0;
      end else begin
         chk("wait_pvld", csb_req_pvld, 0);
         done = 0;
         for (int k = 0; k < TO && !done; k++) begin
            chk("wait_no_cpl", cpl_valid, 0);
            chk("wait_cmd_ready", cmd_ready, 0);
            if (k == resp_dly) begin
               csb_resp_valid = 1'b1;
               csb_resp_pd = {rtype, rerr, rdat};
               tick(); lat++; wait_ticks++;
               csb_resp_valid = 1'b0;
               csb_resp_pd = '0;
               e_rdat = w ? 32'd0 : rdat;
               e_err  = rerr | (rtype != w);
               e_to   = 0;
               done = 1;
            end else if (k == TO - 1) begin
               tick(); lat++; wait_ticks++;
               e_rdat = 0; e_err = 1; e_to = 1;
               done = 1;
            end else begin
               tick(); lat++; wait_ticks++;
            end
         end
         chk("cpl_valid", cpl_valid, 1);
         chk("cpl_cmd_ready", cmd_ready, 1);
      end
      chk("cpl_rdat", cpl_rdat, e_rdat);
      chk("cpl_error", cpl_error, e_err);
      chk("cpl_timeout", cpl_timeout, e_to);
      tick();
      chk("cpl_pulse_end", cpl_valid, 0);
      chk("cpl_rdat_hold", cpl_rdat, e_rdat);
      chk("cpl_error_hold", cpl_error, e_err);
      chk("stray_flag", stray_resp, exp_stray);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, wt;
      logic [21:0] ra;
      logic [31:0] rd, rr;
      logic        rw, rnp, rerr, rtype, rpv;
      logic [3:0]  rbe;
      logic [1:0]  rlv;
      int          pd, rdly;

      // Reset state
      tick(); tick();
      chk_reset_vals("in_reset");
      #3 nvdla_core_rstn = 1'b1;
      tick();
      chk_reset_vals("after_reset");

      // Read, single-cycle responder, prdy high
      run_txn(22'h001234, 32'h0, 1'b0, 1'b0, 4'hF, 1'b0, 2'd0, 0, 0,
              32'hDEADBEEF, 1'b0, 1'b0, lat, wt);
      chk("read_latency", lat, 3);

      // Posted write with prdy delayed 4 cycles
      run_txn(22'h2ABCDE, 32'hCAFEF00D, 1'b1, 1'b0, 4'h5, 1'b1, 2'd3, 4, -1,
              32'h0, 1'b0, 1'b0, lat, wt);
      chk("posted_latency", lat, 6);

      // Non-posted write answered with a read-type response
      run_txn(22'h000040, 32'h12345678, 1'b1, 1'b1, 4'hA, 1'b0, 2'd1, 1, 2,
              32'h55AA55AA, 1'b0, 1'b0, lat, wt);

      // Read timeout: completion after TO wait cycles
      run_txn(22'h3FFFFF, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 2'd2, 0, -1,
              32'h0, 1'b0, 1'b0, lat, wt);
      chk("timeout_wait_cycles", wt, TO);
      // Late response two cycles after the completion
      tick();
      csb_resp_valid = 1'b1;
      csb_resp_pd = {1'b0, 1'b0, 32'h11112222};
      tick();
      csb_resp_valid = 1'b0;
      csb_resp_pd = '0;
      exp_stray = 1'b1;
      chk("late_resp_stray", stray_resp, 1);
      chk("late_resp_not_delivered", cpl_valid, 0);

      // Response on the last counted WAIT cycle wins over timeout
      run_txn(22'h000100, 32'h0, 1'b0, 1'b0, 4'hF, 1'b0, 2'd0, 2, TO - 1,
              32'hA5A5F00F, 1'b0, 1'b0, lat, wt);
      chk("edge_wait_cycles", wt, TO);

      // Randomized transactions
      for (int n = 0; n < 40; n++) begin
         ra = 22'($urandom); rd = $urandom; rr = $urandom;
         rw = 1'($urandom); rnp = 1'($urandom); rpv = 1'($urandom);
         rbe = 4'($urandom); rlv = 2'($urandom);
         pd = $urandom_range(0, 3);
         rdly = $urandom_range(0, TO + 1);
         rerr = ($urandom_range(0, 3) == 0);
         rtype = ($urandom_range(0, 3) == 0) ? ~rw : rw;
         run_txn(ra, rd, rw, rnp, rbe, rpv, rlv, pd, rdly, rr, rerr, rtype, lat, wt);
      end

      // Reset asserted during WAIT
      cmd_addr = 22'h000777; cmd_write = 1'b0; cmd_nposted = 1'b0; cmd_valid = 1'b1;
      csb_req_prdy = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      csb_req_prdy = 1'b0;
      tick(); tick();
      #2 nvdla_core_rstn = 1'b0;
      exp_stray = 1'b0;
      #1;
      chk_reset_vals("mid_wait_reset");
      tick();
      #3 nvdla_core_rstn = 1'b1;
      tick();
      chk("post_reset_no_cpl", cpl_valid, 0);
      chk("post_reset_ready", cmd_ready, 1);
      run_txn(22'h000777, 32'h0, 1'b0, 1'b0, 4'hF, 1'b0, 2'd0, 0, 0,
              32'h0BADCAFE, 1'b0, 1'b0, lat, wt);
      chk("post_reset_latency", lat, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_nvdla_csb_initiator
`default_nettype wire
